// File: rtl/tpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tpu_ctrl_pkg
// Definitions shared by the read and write skew controllers of the systolic
// array: the block-sequencing state enum, the memArr address width and the
// default array dimension.
// -----------------------------------------------------------------------------
package tpu_ctrl_pkg;

  // Block sequencing states used by both rd_control and wr_control.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // memArr banks are addressed with 8 bits.
  localparam int ADDR_W = 8;

  // Default array dimension (and bank count).
  localparam int WIDTH_HEIGHT_DEF = 4;

endpackage : tpu_ctrl_pkg

// File: rtl/wr_control_if.sv
// -----------------------------------------------------------------------------
// wr_control_if
// Bundles the request and write-port signals of wr_control.
//   start      : single-cycle block request
//   num_rows   : rows per bank for the block (N)
//   base_addr  : first address written in every bank
//   wr_en      : per-bank write enable, bit i -> bank i
//   wr_addr    : packed per-bank address, bank i in [8i+7:8i]
//   busy       : block in progress
//   done       : one-cycle completion pulse
// Modports: slave = the controller, master = whoever issues blocks.
// -----------------------------------------------------------------------------
interface wr_control_if
  import tpu_ctrl_pkg::*;
#(
  parameter int width_height = WIDTH_HEIGHT_DEF
);

  logic                             start;
  logic [ADDR_W-1:0]                num_rows;
  logic [ADDR_W-1:0]                base_addr;
  logic [width_height-1:0]          wr_en;
  logic [ADDR_W*width_height-1:0]   wr_addr;
  logic                             busy;
  logic                             done;

  modport slave (
    input  start, num_rows, base_addr,
    output wr_en, wr_addr, busy, done
  );

  modport master (
    output start, num_rows, base_addr,
    input  wr_en, wr_addr, busy, done
  );

endinterface : wr_control_if

// File: rtl/en_skew.sv
// -----------------------------------------------------------------------------
// en_skew
// Staircase enable generator: a width_height-deep registered shift chain.
// Bit 0 is en_i delayed one cycle, bit i is bit i-1 delayed one cycle, so a
// run of en_i pulses sweeps diagonally across the banks.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low clear of the whole chain
//   en_i    : enable entering bank 0
//   en_o    : registered per-bank enables
// -----------------------------------------------------------------------------
module en_skew #(
  parameter int width_height = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en_i,
  output logic [width_height-1:0] en_o
);

  logic [width_height-1:0] en_q;

  // Shifting left moves every enable one bank up; the top bit falls off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= '0;
    end else begin
      en_q <= (en_q << 1) | width_height'(en_i);
    end
  end

  assign en_o = en_q;

endmodule : en_skew

// File: rtl/wr_control.sv
// -----------------------------------------------------------------------------
// wr_control
// Write-side skew controller for the systolic array output. For each block
// it enables bank 0 for N consecutive cycles and lets the enables ripple one
// bank per cycle through the upper banks, matching the array's diagonal
// output wavefront. Each bank has its own address counter that starts at
// base_addr and advances after every enabled write.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : wr_control_if.slave (start/num_rows/base_addr in,
//              wr_en/wr_addr/busy/done out)
// -----------------------------------------------------------------------------
module wr_control
  import tpu_ctrl_pkg::*;
#(
  parameter int width_height = WIDTH_HEIGHT_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  wr_control_if.slave  bus
);

  // Selects the last bank; used to see whether the chain empties next cycle.
  localparam logic [width_height-1:0] TOP_MASK =
    width_height'(1) << (width_height - 1);

  ctrl_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       n_q, n_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    en_in;
  logic                    load;
  logic                    chain_empties;
  logic [width_height-1:0] wr_en;
  logic [ADDR_W*width_height-1:0] wr_addr_flat;

  // With no new enable entering, the chain is all zero next cycle exactly
  // when every bit below the top one is already clear.
  assign chain_empties = ((wr_en & ~TOP_MASK) == '0);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    en_in   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d  = bus.num_rows;
          load = 1'b1;
          if (bus.num_rows == '0) begin
            state_d = DONE;
          end else begin
            // The first bank-0 enable is issued on the start edge itself.
            en_in   = 1'b1;
            cnt_d   = 8'd1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cnt_q != n_q) begin
          en_in = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end else begin
          // A one-bank array has nothing left to drain.
          state_d = chain_empties ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (chain_empties) begin
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  en_skew #(
    .width_height (width_height)
  ) u_en_skew (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en_in),
    .en_o    (wr_en)
  );

  // Per-bank address counters. load only occurs in IDLE, when the enable
  // chain is empty, so it never competes with an increment.
  for (genvar gi = 0; gi < width_height; gi++) begin : g_bank
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        addr_q <= '0;
      end else if (load) begin
        addr_q <= bus.base_addr;
      end else if (wr_en[gi]) begin
        addr_q <= addr_q + 8'd1;
      end
    end

    assign wr_addr_flat[ADDR_W*gi +: ADDR_W] = addr_q;
  end

  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr_flat;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule : wr_control

// File: tb/tb_wr_control.sv
// -----------------------------------------------------------------------------
// tb_wr_control
// Scoreboard bench for wr_control: each accepted start pushes the expected
// per-cycle outputs of the block (from a closed-form timing model) into a
// queue, and a negedge monitor pops and compares one entry per cycle.
// -----------------------------------------------------------------------------
module tb_wr_control;
  import tpu_ctrl_pkg::*;

  localparam int WH = 4;

  typedef struct packed {
    logic [WH-1:0]        en;
    logic [8*WH-1:0]      addr;
    logic                 busy;
    logic                 done;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  wr_control_if #(.width_height(WH)) bus ();

  wr_control #(
    .width_height (WH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle T+k for a block started at edge T.
  function automatic exp_t model(input int n, input logic [7:0] base, input int k);
    exp_t e;
    int   lat;
    int   w;
    lat    = (n == 0) ? 1 : n + WH;
    e      = '0;
    e.busy = (k <= lat);
    e.done = (k == lat);
    for (int i = 0; i < WH; i++) begin
      e.en[i] = (k >= 1 + i) && (k <= n + i);
      w = k - 1 - i;
      if (w < 0) w = 0;
      if (w > n) w = n;
      e.addr[8*i +: 8] = base + 8'(w);
    end
    return e;
  endfunction

  // Block cycles plus the first idle cycle after it.
  task automatic push_block(input int n, input logic [7:0] base);
    int lat;
    lat = (n == 0) ? 1 : n + WH;
    for (int k = 1; k <= lat + 1; k++) exp_q.push_back(model(n, base, k));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("wr_en",   64'(bus.wr_en),   64'(e.en));
      check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
      check("busy",    64'(bus.busy),    64'(e.busy));
      check("done",    64'(bus.done),    64'(e.done));
    end
  end

  task automatic wait_drain();
    int budget;
    budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_block(input int n, input logic [7:0] base);
    @(negedge clk);
    bus.num_rows  = 8'(n);
    bus.base_addr = base;
    bus.start     = 1'b1;
    @(posedge clk);
    push_block(n, base);
    #1 bus.start = 1'b0;
    $display("block N=%0d base=%02h", n, base);
    wait_drain();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.num_rows  = '0;
    bus.base_addr = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    @(negedge clk);
    check("rst_wr_en",   64'(bus.wr_en),   64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_busy",    64'(bus.busy),    64'd0);
    check("rst_done",    64'(bus.done),    64'd0);

    run_block(4, 8'h10);
    run_block(2, 8'h00);
    run_block(3, 8'hFE);
    run_block(0, 8'h40);
    run_block(7, 8'h80);
    run_block(1, 8'h05);

    // start held through a whole block, then num_rows/base_addr change mid-block
    @(negedge clk);
    bus.num_rows  = 8'd4;
    bus.base_addr = 8'h20;
    bus.start     = 1'b1;
    @(posedge clk);
    push_block(4, 8'h20);
    repeat (4 + WH + 1) @(posedge clk);
    push_block(4, 8'h20);
    #1 bus.start = 1'b0;
    $display("held start: two back-to-back blocks N=4 base=20");
    repeat (2) @(posedge clk);
    #1;
    bus.num_rows  = 8'd9;
    bus.base_addr = 8'h77;
    wait_drain();

    // reset in the middle of a block
    @(negedge clk);
    bus.num_rows  = 8'd4;
    bus.base_addr = 8'h10;
    bus.start     = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(4, 8'h10, 1));
    exp_q.push_back(model(4, 8'h10, 2));
    for (int k = 0; k < 4; k++) exp_q.push_back('0);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_wr_en",   64'(bus.wr_en),   64'd0);
    check("mid_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("mid_rst_busy",    64'(bus.busy),    64'd0);
    check("mid_rst_done",    64'(bus.done),    64'd0);
    $display("reset asserted mid-block");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    wait_drain();
    run_block(4, 8'h10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_wr_control
